// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Multi-cycle sequencer for the RV32I core. It walks each instruction through
//   fetch, decode, execute, memory and write-back so that a single memory port
//   and a single ALU serve every step.
//
// Build option:
//   ILLEGAL_TRAP_EN  defined   -> unknown opcodes park the FSM in TRAP until rst;
//                                 the Trap output is present.
//                    undefined -> unknown opcodes retire as a NOP (PC+4, no writes).
//
// Ports:
//   CLK, rst       clock; synchronous active-high reset
//   Run            allow new fetches
//   Opcode/Funct3/Funct7  instruction register fields
//   Mem_Ready      memory completes the current request this cycle
//   Branch_Cond    datapath comparison result for the current branch
//   MEM_*          memory request, address select and store enable
//   IR_Wr_En, Reg_Wr_En, Src_to_Reg   IR latch, RegFile write and its source
//   ALU_Src1_Sel, ALU_Src2_Sel, Sub, ALU_Ctrl   ALU operand and operation select
//   PC_Wr_En, PC_Sel   one strobe per retired instruction and next-PC source
//   Busy           high whenever an instruction is in flight
//   Trap           (ILLEGAL_TRAP_EN only) illegal opcode seen
//   Retired        retired-instruction count, wraps
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_FETCH   | request instruction word at PC, latch IR on Mem_Ready
// S_DECODE  | classify the opcode
// S_EXECUTE | ALU operation; branches resolve and retire here
// S_MEM     | data access at ALU result; stores retire here
// S_WB      | RegFile write and PC update
// S_TRAP    | illegal opcode, held until rst
module multicycle_ctrl_fsm #(
    parameter int ALU_DECODER_IN = 3,
    parameter int CNT_W          = 32
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      Run,
    input  logic [6:0]                Opcode,
    input  logic [2:0]                Funct3,
    input  logic [6:0]                Funct7,
    input  logic                      Mem_Ready,
    input  logic                      Branch_Cond,
    output logic                      MEM_Req,
    output logic                      MEM_Addr_Sel,
    output logic                      MEM_Wr_En,
    output logic                      IR_Wr_En,
    output logic                      Reg_Wr_En,
    output logic [1:0]                Src_to_Reg,
    output logic                      ALU_Src1_Sel,
    output logic                      ALU_Src2_Sel,
    output logic                      Sub,
    output logic [ALU_DECODER_IN-1:0] ALU_Ctrl,
    output logic                      PC_Wr_En,
    output logic [1:0]                PC_Sel,
    output logic                      Busy,
`ifdef ILLEGAL_TRAP_EN
    output logic                      Trap,
`endif
    output logic [CNT_W-1:0]          Retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL, K_JALR,
        K_BRANCH, K_LOAD, K_STORE, K_NOP, K_ILL
    } kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic              fetch_pend_q, fetch_pend_d;
    logic              rst_seen_q, rst_seen_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic              alu_src1, alu_src2, alu_sub, drive_alu;
    logic [2:0]        alu_op;
    logic              unused_funct7;

    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    function automatic kind_e classify(input logic [6:0] op);
        case (op)
            7'h33:        return K_OP;
            7'h13:        return K_OPIMM;
            7'h37:        return K_LUI;
            7'h17:        return K_AUIPC;
            7'h6F:        return K_JAL;
            7'h67:        return K_JALR;
            7'h63:        return K_BRANCH;
            7'h03:        return K_LOAD;
            7'h23:        return K_STORE;
            7'h0F, 7'h73: return K_NOP;
`ifdef ILLEGAL_TRAP_EN
            default:      return K_ILL;
`else
            default:      return K_NOP;
`endif
        endcase
    endfunction

    // ALU selection depends only on the instruction class; it is held through
    // MEM and WB so the address / result stay valid without an ALU output register.
    always_comb begin
        alu_src1 = 1'b0;
        alu_src2 = 1'b0;
        alu_sub  = 1'b0;
        alu_op   = 3'b000;
        case (kind_q)
            K_OP: begin
                alu_op  = Funct3;
                alu_sub = Funct7[5] & ((Funct3 == 3'b000) || (Funct3 == 3'b101));
            end
            K_OPIMM: begin
                alu_src2 = 1'b1;
                alu_op   = Funct3;
                alu_sub  = Funct7[5] & (Funct3 == 3'b101);
            end
            K_LOAD, K_STORE, K_JALR: alu_src2 = 1'b1;
            K_AUIPC, K_JAL: begin
                alu_src1 = 1'b1;
                alu_src2 = 1'b1;
            end
            K_BRANCH: begin
                // BEQ/BNE compare by subtraction, BLT/BGE via SLT, BLTU/BGEU via SLTU
                alu_sub = 1'b1;
                case (Funct3[2:1])
                    2'b10:   alu_op = 3'b010;
                    2'b11:   alu_op = 3'b011;
                    default: alu_op = 3'b000;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        fetch_pend_d = 1'b0;
        rst_seen_d   = rst;
        drive_alu    = 1'b0;
        MEM_Req      = 1'b0;
        MEM_Addr_Sel = 1'b0;
        MEM_Wr_En    = 1'b0;
        IR_Wr_En     = 1'b0;
        Reg_Wr_En    = 1'b0;
        Src_to_Reg   = 2'b00;
        ALU_Src1_Sel = 1'b0;
        ALU_Src2_Sel = 1'b0;
        Sub          = 1'b0;
        ALU_Ctrl     = '0;
        PC_Wr_En     = 1'b0;
        PC_Sel       = 2'b00;
        Busy         = 1'b0;

        case (state_q)
            S_FETCH: begin
                // A started fetch is never abandoned when Run drops; the cycle
                // right after reset never issues a request.
                if (!rst_seen_q && (Run || fetch_pend_q)) begin
                    MEM_Req = 1'b1;
                    if (Mem_Ready) begin
                        IR_Wr_En = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        fetch_pend_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                kind_d = classify(Opcode);
`ifdef ILLEGAL_TRAP_EN
                state_d = (kind_d == K_ILL) ? S_TRAP : S_EXECUTE;
`else
                state_d = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                drive_alu = 1'b1;
                case (kind_q)
                    K_BRANCH: begin
                        PC_Wr_En = 1'b1;
                        PC_Sel   = Branch_Cond ? 2'b01 : 2'b00;
                        state_d  = S_FETCH;
                    end
                    K_LOAD, K_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                drive_alu    = 1'b1;
                MEM_Req      = 1'b1;
                MEM_Addr_Sel = 1'b1;
                MEM_Wr_En    = (kind_q == K_STORE);
                if (Mem_Ready) begin
                    if (kind_q == K_STORE) begin
                        PC_Wr_En = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                drive_alu = 1'b1;
                PC_Wr_En  = 1'b1;
                state_d   = S_FETCH;
                case (kind_q)
                    K_OP, K_OPIMM, K_AUIPC: Reg_Wr_En = 1'b1;
                    K_LOAD: begin
                        Reg_Wr_En  = 1'b1;
                        Src_to_Reg = 2'b01;
                    end
                    K_JAL: begin
                        Reg_Wr_En  = 1'b1;
                        Src_to_Reg = 2'b10;
                        PC_Sel     = 2'b01;
                    end
                    K_JALR: begin
                        Reg_Wr_En  = 1'b1;
                        Src_to_Reg = 2'b10;
                        PC_Sel     = 2'b10;
                    end
                    K_LUI: begin
                        Reg_Wr_En  = 1'b1;
                        Src_to_Reg = 2'b11;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (drive_alu) begin
            ALU_Src1_Sel = alu_src1;
            ALU_Src2_Sel = alu_src2;
            Sub          = alu_sub;
            ALU_Ctrl     = ALU_DECODER_IN'(alu_op);
        end

        Busy = (state_q != S_FETCH) || MEM_Req;

        // Outputs are quiet for the whole reset cycle, whatever state it interrupts.
        if (rst) begin
            MEM_Req      = 1'b0;
            MEM_Addr_Sel = 1'b0;
            MEM_Wr_En    = 1'b0;
            IR_Wr_En     = 1'b0;
            Reg_Wr_En    = 1'b0;
            Src_to_Reg   = 2'b00;
            ALU_Src1_Sel = 1'b0;
            ALU_Src2_Sel = 1'b0;
            Sub          = 1'b0;
            ALU_Ctrl     = '0;
            PC_Wr_En     = 1'b0;
            PC_Sel       = 2'b00;
            Busy         = 1'b0;
        end

        retired_d = retired_q + CNT_W'(PC_Wr_En);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= S_FETCH;
            kind_q       <= K_NOP;
            fetch_pend_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            fetch_pend_q <= fetch_pend_d;
            retired_q    <= retired_d;
        end
        rst_seen_q <= rst_seen_d;
    end

    assign Retired = rst ? '0 : retired_q;
`ifdef ILLEGAL_TRAP_EN
    assign Trap = !rst && (state_q == S_TRAP);
`endif

endmodule
